ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the attached keyboard, the opposite direction of the existing PS/2 keyboard receiver. It runs in the `clk` domain (Div[0] in `top`) and drives the PS/2 clock and data lines as open-drain through `*_oe` outputs; the IOBUF sits at top level. While `busy` is high the receiver's output must be treated as invalid.

## Interface
- `INHIBIT_CYCLES`, 5000: clk cycles the host holds PS/2 clock low before the request (≥100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: max clk cycles allowed between device clock falling edges, and from release to the first edge (15 ms at 50 MHz).
- `TIMER_W`, 20: timer width; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `din` in 8: command byte. Captured on the cycle `start` is accepted.
- `ps2_clk_in` in 1: PS/2 clock pad value. Asynchronous.
- `ps2_data_in` in 1: PS/2 data pad value. Asynchronous.
- `ps2_clk_oe` out 1: 1 drives the clock pad low, 0 releases it.
- `ps2_data_oe` out 1: 1 drives the data pad low, 0 releases it.
- `busy` out 1: high from the accept cycle until `done` or `timeout`.
- `done` out 1: one-cycle pulse when a frame completes.
- `ack_ok` out 1: valid in the `done` cycle. 1 means the device drove the ack bit low.
- `timeout` out 1: one-cycle pulse when a transfer is aborted.

## Operation
- Synchronizer: two flops on each pad input, giving `sclk` and `sdata`. A third flop on `sclk` gives the falling-edge strobe `fall = prev & ~sclk`. All protocol decisions use the synced values.
- Frame: shift register `{stop=1, parity, din[7:0]}`, sent LSB first. Parity is odd: `~^din`.
- States:
  - **IDLE**: both oe are 0 and `busy` is 0. When `start` is seen: latch the frame, clear the timer, set `busy`, go to INHIBIT.
  - **INHIBIT**: `ps2_clk_oe=1`, `ps2_data_oe=0`. When timer reaches INHIBIT_CYCLES-1, go to REQ.
  - **REQ**: exactly one cycle with `ps2_clk_oe=1` and `ps2_data_oe=1` (start bit). Next: RELEASE, with the timer cleared.
  - **RELEASE/SEND**: `ps2_clk_oe=0`. `ps2_data_oe` holds the start bit (1) until the first `fall`. On each `fall`, `ps2_data_oe <= ~shift[0]`, shift right, bit counter +1, timer cleared.
    - After the 10th `fall` (stop bit placed, data released), go to ACK.
  - **ACK**: both oe are 0. On the next `fall`, latch `ack_ok <= ~sdata` and go to WAITIDLE.
  - **WAITIDLE**: wait until `sclk` and `sdata` are both 1. In that cycle pulse `done`, clear `busy`, go to IDLE.
- Timeout: in RELEASE, SEND and ACK the timer counts cycles since the last `fall` (or since entering RELEASE). In WAITIDLE it counts cycles since entry. When the timer reaches TIMEOUT_CYCLES-1:
  - both oe go to 0 and `timeout` pulses on the next cycle;
  - `busy` clears, `ack_ok` goes to 0, state goes to IDLE;
  - `done` does not pulse.
- `start` while `busy` is ignored. It is not queued.
- Device-driven clock activity in IDLE is ignored; the receiver owns it.

## Timing
- Reset values: `ps2_clk_oe=0`, `ps2_data_oe=0`, `busy=0`, `done=0`, `ack_ok=0`, `timeout=0`. Synchronizer flops reset to 1 (idle bus).
- `rst` mid-frame: both lines are released in the cycle after `rst` is sampled. No `done` or `timeout` pulse.
- `start` at cycle N: `busy=1` and `ps2_clk_oe=1` at N+1.
- Line sequence: `ps2_clk_oe` stays high for INHIBIT_CYCLES+1 cycles. `ps2_data_oe` rises at N+1+INHIBIT_CYCLES. `ps2_clk_oe` falls one cycle later.
- Pad-to-action latency: a pad falling edge at cycle M gives `fall` at M+2. `ps2_data_oe` updates at M+3. This is well inside the device's ~40 µs low phase.
- All outputs are registered. `done` and `timeout` are never high together. `done` and `busy` fall in the same cycle.

## Test plan
- Send 0xED to a device BFM (clock period 80 µs, ack enabled). Required:
  - inhibit lasts 5000 cycles;
  - on the BFM's rising edges the line reads start 0, then 1,0,1,1,0,1,1,1, then parity 1, then stop 1;
  - the BFM drives ack low; `done` pulses with `ack_ok=1`; `busy` falls in the same cycle.
- Send 0x00: parity bit sampled is 1. Send 0xFF: parity bit sampled is 1. Send 0x01: parity bit sampled is 0.
- BFM does not ack (data stays high on the 11th edge). Required: `done` pulses with `ack_ok=0`.
- BFM stops clocking after 4 edges. Required: `timeout` pulses exactly TIMEOUT_CYCLES cycles after the 4th `fall`; both oe are 0; `busy=0`; a new `start` is accepted afterwards.
- Assert `rst` during SEND (after bit 3). Required: both oe are 0 the next cycle; all outputs at reset values; no pulses. A following 0xF4 completes correctly.
- Pulse `start` again while `busy`, with `din=0x55`. Required: ignored; the original byte 0xED is the one transmitted; only one `done` pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte out on device clock falling edges and collects the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int TIMER_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAITIDLE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         clk_sync_q, clk_sync_d;
  logic [1:0]         data_sync_q, data_sync_d;
  logic [9:0]         shift_q, shift_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ack_ok_q, ack_ok_d;
  logic               timeout_q, timeout_d;

  logic sclk, sdata, fall, expired;

  // Stage [0] is the metastability catcher; [2] is the previous sclk for edge detection.
  assign clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
  assign data_sync_d = {data_sync_q[0], ps2_data_in};
  assign sclk        = clk_sync_q[1];
  assign sdata       = data_sync_q[1];
  assign fall        = clk_sync_q[2] & ~clk_sync_q[1];
  assign expired     = (timer_q == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      shift_q     <= '1;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_ok_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_ok_q    <= ack_ok_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_ok_d  = ack_ok_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          shift_d   = {1'b1, ~^din, din};
          bit_cnt_d = '0;
          timer_d   = '0;
          busy_d    = 1'b1;
          ack_ok_d  = 1'b0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        timer_d = timer_q + TIMER_ONE;
        if (timer_q == INHIBIT_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        clk_oe_d = 1'b0;
        timer_d  = '0;
        state_d  = S_SEND;
      end

      S_SEND: begin
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      S_ACK: begin
        if (fall) begin
          ack_ok_d = ~sdata;
          timer_d  = '0;
          state_d  = S_WAITIDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      S_WAITIDLE: begin
        if (sclk && sdata) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A device edge in the expiring cycle still counts; otherwise abandon the frame.
    if ((state_q == S_SEND || state_q == S_ACK || state_q == S_WAITIDLE) &&
        expired && !fall && !(state_q == S_WAITIDLE && sclk && sdata)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      ack_ok_d  = 1'b0;
      timeout_d = 1'b1;
      timer_d   = '0;
      state_d   = S_IDLE;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain PS/2 device model clocks frames
// out of the host and the observed bits, pulses and latencies are checked.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TO  = 600;
  localparam int H   = 20;   // device half clock period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .TIMER_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .din(din),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .ack_ok(ack_ok),
    .timeout(timeout)
  );

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (timeout) to_cnt++;
    if (done && timeout) overlap++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start, then watch the inhibit and request phases up to clock release.
  task automatic begin_frame(input logic [7:0] b, input bit poke);
    int  n;
    logic last_doe;
    @(negedge clk);
    start = 1'b1;
    din   = b;
    @(negedge clk);
    start = 1'b0;
    din   = 8'h00;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_clk_oe", ps2_clk_oe, 1);
    n = 0;
    last_doe = 1'b0;
    while (ps2_clk_oe && n < 4 * INH) begin
      n++;
      if (n == 1) check_eq("inhibit_data_free", ps2_data_oe, 0);
      last_doe = ps2_data_oe;
      if (poke && n == 3) begin
        start = 1'b1;
        din   = 8'h55;
      end else begin
        start = 1'b0;
        din   = 8'h00;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("inhibit_len", n, INH + 1);
    check_eq("req_data_low", last_doe, 1);
    check_eq("release_data_held", ps2_data_oe, 1);
  endtask

  // Device samples the start bit on the release edge, then issues nf clock pulses.
  task automatic clock_falls(input int nf, input logic [7:0] b, output logic [10:0] bits);
    logic exp_b0;
    exp_b0 = ~b[0];
    bits = '1;
    bits[0] = ps2_data_in;
    repeat (H) @(negedge clk);
    for (int k = 1; k <= nf; k++) begin
      dev_clk_low = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (k == 1) check_eq("fall_lat_hold", ps2_data_oe, 1);
      @(negedge clk);
      if (k == 1) check_eq("fall_lat_update", ps2_data_oe, exp_b0);
      repeat (H - 3) @(negedge clk);
      dev_clk_low = 1'b0;
      bits[k] = ps2_data_in;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic par, input bit ack, input bit poke);
    logic [10:0] bits;
    logic [10:0] exp_bits;
    int n, dc0, tc0;
    dc0 = done_cnt;
    tc0 = to_cnt;
    exp_bits = {1'b1, par, b, 1'b0};
    begin_frame(b, poke);
    clock_falls(10, b, bits);
    dev_data_low = ack;
    dev_clk_low  = 1'b1;
    repeat (H) @(negedge clk);
    check_eq("ack_lines_free", {ps2_clk_oe, ps2_data_oe}, 0);
    check_eq("ack_still_busy", busy, 1);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    n = 0;
    while (!done && !timeout && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", done, 1);
    check_eq("ack_ok", ack_ok, ack);
    check_eq("busy_with_done", busy, 0);
    check_eq("frame_bits", bits, exp_bits);
    repeat (3) @(negedge clk);
    check_eq("done_once", done_cnt, dc0 + 1);
    check_eq("no_timeout", to_cnt, tc0);
    $display("frame din=%02h bits=%011b ack_ok=%0b", b, bits, ack_ok);
  endtask

  initial begin
    logic [10:0] bits;
    int n, dc0, tc0;

    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle_outputs", {ps2_clk_oe, ps2_data_oe, busy}, 0);

    run_frame(8'hED, 1'b1, 1'b1, 1'b0);
    run_frame(8'h00, 1'b1, 1'b1, 1'b0);
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    run_frame(8'h01, 1'b0, 1'b1, 1'b0);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0);

    // Device stops clocking after four edges.
    dc0 = done_cnt;
    tc0 = to_cnt;
    begin_frame(8'h3C, 1'b0);
    clock_falls(3, 8'h3C, bits);
    dev_clk_low = 1'b1;
    n = 0;
    while (!timeout && n < 2 * TO) begin
      @(negedge clk);
      n++;
      if (n == H) dev_clk_low = 1'b0;
    end
    check_eq("timeout_seen", timeout, 1);
    check_eq("timeout_latency", n - 3, TO);
    check_eq("timeout_lines", {ps2_clk_oe, ps2_data_oe, busy, ack_ok, done}, 0);
    @(negedge clk);
    check_eq("timeout_pulse_len", timeout, 0);
    check_eq("timeout_no_done", done_cnt, dc0);
    check_eq("timeout_count", to_cnt, tc0 + 1);
    $display("frame din=3c aborted after %0d cycles", n);
    run_frame(8'h00, 1'b1, 1'b1, 1'b0);

    // Reset while bits are being shifted out.
    dc0 = done_cnt;
    tc0 = to_cnt;
    begin_frame(8'hED, 1'b0);
    clock_falls(4, 8'hED, bits);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("midrst_no_pulses", done_cnt + to_cnt, dc0 + tc0);
    $display("frame din=ed reset mid-frame bits=%011b", bits);
    run_frame(8'hF4, 1'b0, 1'b1, 1'b0);

    // Second start while busy must be ignored.
    run_frame(8'hED, 1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("poke_not_queued", busy, 0);

    check_eq("total_done", done_cnt, 8);
    check_eq("total_timeout", to_cnt, 1);
    check_eq("done_timeout_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
